// File: rtl/rect_blitter.sv
// Rectangle plotter: takes one draw command (fill, outline or clear screen) and
// scans it row-major, emitting one clipped pixel slot per cycle to the frame-buffer adapter.
module rect_blitter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               reset,
    // A command transfers on a rising edge where req_valid && req_ready; the requester
    // holds req_valid and the fields stable until then, and the fields are ignored afterwards.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_mode,
    input  logic [X_W-1:0]     req_x,
    input  logic [Y_W-1:0]     req_y,
    input  logic [X_W-1:0]     req_w,
    input  logic [Y_W-1:0]     req_h,
    input  logic [COLOR_W-1:0] req_color,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               writeEn,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [X_W:0]   SCR_W_X = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SCR_H_Y = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W-1:0] CLR_W   = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] CLR_H   = Y_W'(SCREEN_H);
    localparam logic [X_W-1:0] X_ONE   = 1;
    localparam logic [Y_W-1:0] Y_ONE   = 1;

    state_t               state_q, state_d;
    logic [X_W-1:0]       bx_q, bw_q, cx_q;
    logic [Y_W-1:0]       by_q, bh_q, cy_q;
    logic [COLOR_W-1:0]   col_q;
    logic                 outline_q;
    logic                 scan_end_q;

    logic                 is_clear, eff_zero, accept;
    logic [X_W-1:0]       eff_x, eff_w;
    logic [Y_W-1:0]       eff_y, eff_h;

    logic [X_W-1:0]       src_x, src_w, src_cx, cx_d;
    logic [Y_W-1:0]       src_y, src_h, src_cy, cy_d;
    logic [COLOR_W-1:0]   src_color;
    logic                 src_outline, slot_emit;
    logic [X_W:0]         px;
    logic [Y_W:0]         py;
    logic                 row_end, last_row, on_edge, in_bounds, slot_write, slot_last;

    // Clear mode replaces the geometry with the whole screen.
    always_comb begin
        is_clear = (req_mode == 2'b10);
        eff_x    = is_clear ? '0 : req_x;
        eff_y    = is_clear ? '0 : req_y;
        eff_w    = is_clear ? CLR_W : req_w;
        eff_h    = is_clear ? CLR_H : req_h;
        eff_zero = (eff_w == '0) || (eff_h == '0);
    end

    assign accept = (state_q == ST_IDLE) && req_valid;

    // The first slot is evaluated straight from the request so that it is registered on the
    // handshake edge itself; later slots come from the latched command and the scan counters.
    always_comb begin
        if (state_q == ST_IDLE) begin
            src_x       = eff_x;
            src_y       = eff_y;
            src_w       = eff_w;
            src_h       = eff_h;
            src_color   = req_color;
            src_outline = (req_mode == 2'b01);
            src_cx      = '0;
            src_cy      = '0;
            slot_emit   = req_valid && !eff_zero;
        end else begin
            src_x       = bx_q;
            src_y       = by_q;
            src_w       = bw_q;
            src_h       = bh_q;
            src_color   = col_q;
            src_outline = outline_q;
            src_cx      = cx_q;
            src_cy      = cy_q;
            slot_emit   = (state_q == ST_DRAW) && !scan_end_q;
        end
    end

    always_comb begin
        px         = {1'b0, src_x} + {1'b0, src_cx};
        py         = {1'b0, src_y} + {1'b0, src_cy};
        row_end    = (src_cx == src_w - X_ONE);
        last_row   = (src_cy == src_h - Y_ONE);
        on_edge    = (src_cx == '0) || row_end || (src_cy == '0) || last_row;
        in_bounds  = (px < SCR_W_X) && (py < SCR_H_Y);
        slot_write = slot_emit && in_bounds && (!src_outline || on_edge);
        slot_last  = row_end && last_row;
        cx_d       = row_end ? '0 : src_cx + X_ONE;
        cy_d       = row_end ? src_cy + Y_ONE : src_cy;
    end

    // DRAW stays one extra cycle after the last slot is emitted so done lines up with
    // the cycle after the last pixel appears on the registered outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = eff_zero ? ST_DONE : ST_DRAW;
            ST_DRAW: if (scan_end_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bx_q       <= '0;
            by_q       <= '0;
            bw_q       <= '0;
            bh_q       <= '0;
            col_q      <= '0;
            outline_q  <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            scan_end_q <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            color_out  <= '0;
            writeEn    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bx_q       <= eff_x;
                by_q       <= eff_y;
                bw_q       <= eff_w;
                bh_q       <= eff_h;
                col_q      <= req_color;
                outline_q  <= (req_mode == 2'b01);
                cx_q       <= '0;
                cy_q       <= '0;
                scan_end_q <= 1'b0;
            end
            if (slot_emit) begin
                cx_q       <= cx_d;
                cy_q       <= cy_d;
                scan_end_q <= slot_last;
            end
            writeEn <= slot_write;
            if (slot_write) begin
                x_out     <= px[X_W-1:0];
                y_out     <= py[Y_W-1:0];
                color_out <= src_color;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign req_ready = !busy;
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rect_blitter.sv
// Bench for rect_blitter: each command is checked cycle by cycle against a reference
// that enumerates the rectangle's pixels with plain arithmetic.
module tb_rect_blitter;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_mode;
    logic [7:0] req_x, req_w;
    logic [6:0] req_y, req_h;
    logic [2:0] req_color;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;
    logic       writeEn, busy, done;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Outputs hold their last written value; the reference tracks that too.
    int hx = 0, hy = 0, hc = 0;

    // One word per cycle after the handshake: {writeEn, done, busy, x, y, colour}
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];

    rect_blitter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_color(req_color),
        .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .writeEn(writeEn), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pack(int we, int dn, int x, int y, int c);
        logic [31:0] xv, yv, cv;
        xv = x; yv = y; cv = c;
        return {we[0], dn[0], 1'b1, xv[7:0], yv[6:0], cv[2:0]};
    endfunction

    // Reference: enumerate the rectangle's pixels in raster order and decide each one.
    function automatic void build_expected(int mode, int x, int y, int w, int h, int color);
        int n, cx, cy, px, py;
        bit wr, edge_px;
        exp_q.delete();
        if (mode == 2) begin
            x = 0; y = 0; w = SW; h = SH;
        end
        n = w * h;
        for (int s = 0; s < n; s++) begin
            cx = s % w;
            cy = s / w;
            px = x + cx;
            py = y + cy;
            edge_px = (cx == 0) || (cx == w - 1) || (cy == 0) || (cy == h - 1);
            wr = (px < SW) && (py < SH) && (mode != 1 || edge_px);
            if (wr) begin
                hx = px; hy = py; hc = color;
            end
            exp_q.push_back(pack(wr, 0, hx, hy, hc));
        end
        exp_q.push_back(pack(0, 1, hx, hy, hc));
    endfunction

    function automatic int count_writes();
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][20]) n++;
        return n;
    endfunction

    // Drives one command, scrambles the fields after acceptance and records the outputs
    // for as many cycles as the reference expects. pulse_k > 0 raises a stray request in that cycle.
    task automatic drive_cmd(input int mode, x, y, w, h, color, input int pulse_k);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_cmd: req_ready=%b required 1", req_ready);
        end
        req_mode = mode[1:0]; req_x = x[7:0]; req_y = y[6:0];
        req_w = w[7:0]; req_h = h[6:0]; req_color = color[2:0];
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_mode = 2'($urandom); req_x = 8'($urandom); req_y = 7'($urandom);
        req_w = 8'($urandom); req_h = 7'($urandom); req_color = 3'($urandom);
        obs_q.delete();
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            obs_q.push_back({writeEn, done, busy, x_out, y_out, color_out});
            if (k == pulse_k) begin
                req_valid = 1'b1; req_mode = 2'b00; req_x = 8'd1; req_y = 7'd1;
                req_w = 8'd5; req_h = 7'd5; req_color = 3'd7;
            end else begin
                req_valid = 1'b0;
            end
        end
        if (req_valid) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0;
        req_mode = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({writeEn, busy, done, req_ready, x_out, y_out, color_out} !== {4'b0001, 18'd0}) begin
            errors++;
            $display("FAIL reset_state: we=%b busy=%b done=%b ready=%b x=%0d y=%0d c=%0d required 0 0 0 1 0 0 0",
                     writeEn, busy, done, req_ready, x_out, y_out, color_out);
        end
        reset = 1'b0;
        hx = 0; hy = 0; hc = 0;
    endtask

    task automatic test_fill();
        build_expected(0, 10, 20, 3, 2, 5);
        drive_cmd(0, 10, 20, 3, 2, 5, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL fill cycle %0d: got %b_%b_%b x=%0d y=%0d c=%0d required %b_%b_%b x=%0d y=%0d c=%0d", k + 1,
                         obs_q[k][20], obs_q[k][19], obs_q[k][18], obs_q[k][17:10], obs_q[k][9:3], obs_q[k][2:0],
                         exp_q[k][20], exp_q[k][19], exp_q[k][18], exp_q[k][17:10], exp_q[k][9:3], exp_q[k][2:0]);
            end
        end
        checks++;
        if (count_writes() != 6) begin
            errors++;
            $display("FAIL fill_write_count: got %0d required 6", count_writes());
        end
    endtask

    task automatic test_outline();
        build_expected(1, 0, 0, 4, 3, 2);
        drive_cmd(1, 0, 0, 4, 3, 2, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL outline cycle %0d: got %h required %h (we,done,busy,x,y,c packed)", k + 1, obs_q[k], exp_q[k]);
            end
        end
        checks++;
        if (count_writes() != 10 || obs_q.size() != 13) begin
            errors++;
            $display("FAIL outline_count: got writes=%0d cycles=%0d required 10 and 13", count_writes(), obs_q.size());
        end
    endtask

    task automatic test_clip();
        build_expected(0, 158, 119, 4, 2, 6);
        drive_cmd(0, 158, 119, 4, 2, 6, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL clip cycle %0d: got %h required %h (we,done,busy,x,y,c packed)", k + 1, obs_q[k], exp_q[k]);
            end
        end
        checks++;
        if (count_writes() != 2 || obs_q.size() != 9) begin
            errors++;
            $display("FAIL clip_count: got writes=%0d cycles=%0d required 2 and 9", count_writes(), obs_q.size());
        end
    endtask

    task automatic test_clear();
        int gx, gy, gw, gh;
        gx = $urandom_range(0, 255); gy = $urandom_range(0, 127);
        gw = $urandom_range(0, 255); gh = $urandom_range(0, 127);
        build_expected(2, gx, gy, gw, gh, 0);
        drive_cmd(2, gx, gy, gw, gh, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL clear cycle %0d: got %h required %h (we,done,busy,x,y,c packed)", k + 1, obs_q[k], exp_q[k]);
            end
        end
        checks++;
        if (count_writes() != 19200 || obs_q.size() != 19201) begin
            errors++;
            $display("FAIL clear_count: got writes=%0d cycles=%0d required 19200 and 19201", count_writes(), obs_q.size());
        end
    endtask

    task automatic test_zero_size();
        build_expected(0, 30, 40, 0, 5, 3);
        drive_cmd(0, 30, 40, 0, 5, 3, 1);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL zero_size: got %h required %h (we,done,busy,x,y,c packed)", obs_q[0], exp_q[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, writeEn, req_ready} !== 3'b001) begin
                errors++;
                $display("FAIL ignored_while_busy %0d: busy=%b we=%b ready=%b required 0 0 1", k, busy, writeEn, req_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_mode = 2'b00; req_x = 8'd50; req_y = 7'd60; req_w = 8'd10; req_h = 7'd10; req_color = 3'd4;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({writeEn, busy, done, req_ready, x_out, y_out, color_out} !== {4'b0001, 18'd0}) begin
            errors++;
            $display("FAIL reset_mid: we=%b busy=%b done=%b ready=%b x=%0d y=%0d c=%0d required 0 0 0 1 0 0 0",
                     writeEn, busy, done, req_ready, x_out, y_out, color_out);
        end
        @(negedge clk);
        reset = 1'b0;
        hx = 0; hy = 0; hc = 0;
        build_expected(0, 3, 4, 2, 2, 6);
        drive_cmd(0, 3, 4, 2, 2, 6, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %h required %h (we,done,busy,x,y,c packed)", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int m, x, y, w, h, c;
        for (int t = 0; t < 30; t++) begin
            m = $urandom_range(0, 3);
            x = $urandom_range(0, 255); y = $urandom_range(0, 127);
            w = $urandom_range(0, 12);  h = $urandom_range(0, 8);
            c = $urandom_range(0, 7);
            if (t % 3 == 0) begin
                x = $urandom_range(150, 160); y = $urandom_range(112, 120);
            end
            if (m == 2) m = 1;
            build_expected(m, x, y, w, h, c);
            drive_cmd(m, x, y, w, h, c, 0);
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL random t=%0d m=%0d (%0d,%0d %0dx%0d) cycle %0d: got %h required %h (we,done,busy,x,y,c packed)",
                             t, m, x, y, w, h, k + 1, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_outline();
        test_clip();
        test_clear();
        test_zero_size();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_blitter.md
Name: rect_blitter

Overview:
- Parametrised rectangle plotter between the game processor and the VGA frame-buffer adapter.
- Accepts one draw command at a time via a valid/ready handshake.
- Scans the rectangle row-major and emits one pixel per cycle on a plot interface (x, y, colour, write enable).
- Supports filled, outline and clear-screen modes, with clipping to screen bounds, so sprites and wall segments can be drawn without per-pixel processor work.

Parameters:
- X_W, 8, width of x coordinate and rectangle width field
- Y_W, 7, width of y coordinate and rectangle height field
- COLOR_W, 3, colour width
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  block can accept a command (high only in IDLE)
- req_mode  in  2  00 fill, 01 outline, 10 clear screen, 11 reserved (treated as fill)
- req_x  in  X_W  top-left x
- req_y  in  Y_W  top-left y
- req_w  in  X_W  width in pixels
- req_h  in  Y_W  height in pixels
- req_color  in  COLOR_W  draw colour
- x_out  out  X_W  pixel x to adapter
- y_out  out  Y_W  pixel y to adapter
- color_out  out  COLOR_W  pixel colour to adapter
- writeEn  out  1  plot strobe, one pixel per high cycle
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after the last pixel slot of a command

Behaviour:
- Reset (async, any state including mid-draw):
  - state = IDLE; all counters and latched fields cleared.
  - x_out = 0, y_out = 0, color_out = 0, writeEn = 0, busy = 0, done = 0, req_ready = 1.
  - The command in progress is abandoned with no further writes.
- States: IDLE, DRAW, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at a rising edge, latch mode, x, y, w, h and colour.
  - Clear mode overrides the geometry: x = 0, y = 0, w = SCREEN_W, h = SCREEN_H.
  - If the effective w == 0 or h == 0, go to DONE with no pixels emitted. Otherwise go to DRAW with cx = 0, cy = 0.
- DRAW:
  - One pixel slot per cycle, row-major, cx fastest.
  - Coordinate sums px = x + cx and py = y + cy are computed one bit wider than X_W and Y_W respectively, so overflow is not lost.
  - A slot writes (writeEn = 1) only when px < SCREEN_W, py < SCREEN_H, and either mode is not outline or the pixel is on an edge (cx == 0, cx == w-1, cy == 0 or cy == h-1).
  - A clipped or interior slot still consumes its cycle, with writeEn = 0 and x_out/y_out/color_out holding their previous values.
  - When cx == w-1: cx wraps to 0 and cy increments. The slot with cx == w-1 and cy == h-1 is the last; go to DONE.
- Outputs are registered:
  - The slot for pixel k (k = 1..w*h) appears on the outputs in the k-th cycle after the handshake edge.
  - writeEn is therefore high only in cycles 1..w*h after acceptance.
- DONE: done = 1 for exactly one cycle (cycle w*h+1, or cycle 1 for zero-size commands), then IDLE. req_ready is high again in the following cycle.
- busy = 1 in DRAW and DONE; req_ready = !busy. A req_valid that arrives while busy is ignored and must be held by the requester.
- Width/height of 1 in outline mode: every pixel is an edge, identical to fill.
- Request fields may change after acceptance without effect.

Test Plan:
- Reset, then fill x=10, y=20, w=3, h=2, colour 5 -> writeEn in cycles 1..6 after the handshake with (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), colour 5; done in cycle 7; req_ready high in cycle 8.
- Outline x=0, y=0, w=4, h=3 -> 12 slots, writeEn high in 10 of them; (1,1) and (2,1) are never written; done in cycle 13.
- Clipping: fill x=158, y=119, w=4, h=2 -> exactly one write at (158,119) and one at (159,119); 8 slots total; done in cycle 9.
- Clear mode with colour 0 and arbitrary geometry inputs -> 19200 writes covering (0,0)..(159,119) in row-major order; done in cycle 19201.
- Zero size (w=0, h=5) -> no writeEn; done in cycle 1; a second command pulsed during busy is not accepted.
- Assert reset in the middle of a 100-pixel fill -> writeEn, busy and done are 0 immediately; after release req_ready = 1 and the next command scans from its own origin.
